// File: rtl/nios2_debug_vjtag_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: one command in, one full
// UIR/CDR/SDR/UDR/RTI scan on vji_*, captured DR returned as a response.
module nios2_debug_vjtag_master #(
    parameter int unsigned TCK_DIV     = 4,
    parameter int unsigned DR_WIDTH    = 38,
    parameter int unsigned IR_WIDTH    = 2,
    parameter int unsigned RTI_PERIODS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int unsigned PerMax = (DR_WIDTH > RTI_PERIODS) ? DR_WIDTH : RTI_PERIODS;
    localparam int unsigned PerW   = (PerMax > 1) ? $clog2(PerMax) : 1;
    localparam int unsigned DivW   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(TCK_DIV - 1);
    localparam logic [PerW-1:0] SdrLast = PerW'(DR_WIDTH - 1);
    localparam logic [PerW-1:0] RtiLast = PerW'(RTI_PERIODS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StUir,
        StCdr,
        StSdr,
        StUdr,
        StRti,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [DivW-1:0]     div_q, div_d;
    logic [PerW-1:0]     per_q, per_d;
    logic                tck_q, tck_d;
    logic                tdi_q, tdi_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
    logic [4:0]          ind_q, ind_d;
    logic                rsp_valid_q, rsp_valid_d;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        per_d    = per_q;
        tck_d    = tck_q;
        tdi_d    = tdi_q;
        sr_d     = sr_q;
        ir_in_d  = ir_in_q;
        ir_out_d = ir_out_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StUir;
                    ir_in_d = cmd_ir;
                    sr_d    = cmd_data;
                    div_d   = '0;
                    per_d   = '0;
                    tck_d   = 1'b0;
                    tdi_d   = 1'b0;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (div_q != DivLast) begin
                    div_d = div_q + DivW'(1);
                end else begin
                    div_d = '0;
                    tck_d = ~tck_q;
                    if (!tck_q) begin
                        // tck rising: sample slave outputs, never touch state outputs here
                        if (state_q == StUir) ir_out_d = vji_ir_out;
                        if (state_q == StSdr) sr_d = {vji_tdo, sr_q[DR_WIDTH-1:1]};
                    end else begin
                        // tck falling closes a period; all output changes happen here
                        case (state_q)
                            StUir: state_d = StCdr;
                            StCdr: begin
                                state_d = StSdr;
                                per_d   = '0;
                                tdi_d   = sr_q[0];
                            end
                            StSdr: begin
                                if (per_q == SdrLast) begin
                                    state_d = StUdr;
                                    tdi_d   = 1'b0;
                                end else begin
                                    per_d = per_q + PerW'(1);
                                    tdi_d = sr_q[0];
                                end
                            end
                            StUdr: begin
                                state_d = StRti;
                                per_d   = '0;
                            end
                            StRti: begin
                                if (per_q == RtiLast) begin
                                    state_d = StResp;
                                end else begin
                                    per_d = per_q + PerW'(1);
                                end
                            end
                            default: state_d = StIdle;
                        endcase
                    end
                end
            end
        endcase

        ind_d = 5'b0;
        case (state_d)
            StUir:   ind_d = 5'b10000;
            StCdr:   ind_d = 5'b01000;
            StSdr:   ind_d = 5'b00100;
            StUdr:   ind_d = 5'b00010;
            StRti:   ind_d = 5'b00001;
            default: ind_d = 5'b0;
        endcase
        rsp_valid_d = (state_d == StResp);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            div_q       <= '0;
            per_q       <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            sr_q        <= '0;
            ir_in_q     <= '0;
            ir_out_q    <= '0;
            ind_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            per_q       <= per_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            sr_q        <= sr_d;
            ir_in_q     <= ir_in_d;
            ir_out_q    <= ir_out_d;
            ind_q       <= ind_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = sr_q;
    assign rsp_ir_out = ir_out_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = tdi_q;
    assign vji_ir_in  = ir_in_q;
    assign {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} = ind_q;

endmodule

// File: tb/tb_nios2_debug_vjtag_master.sv
// Scoreboard bench for nios2_debug_vjtag_master: random commands against a shift-register
// slave model, plus a TCK_DIV=1 all-ones loopback instance.
module tb_nios2_debug_vjtag_master;

    localparam int unsigned DRW  = 38;
    localparam int unsigned IRW  = 2;
    localparam int unsigned RTI  = 2;
    localparam int unsigned DIV0 = 4;
    localparam int unsigned DIV1 = 1;
    // accept-to-rsp_valid latency in clk, measured as in the timing rules
    localparam int LAT0 = 1 + 2 * DIV0 * (DRW + 3 + RTI);
    localparam int LAT1 = 1 + 2 * DIV1 * (DRW + 3 + RTI);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DRW-1:0] rnd38();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DRW-1:0];
    endfunction

    // ---------------- DUT 0: default parameters ----------------
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir = '0;
    logic [DRW-1:0] cmd_data = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [DRW-1:0] rsp_data;
    logic [IRW-1:0] rsp_ir_out;
    logic           vji_tck, vji_tdi, vji_tdo;
    logic [IRW-1:0] vji_ir_in;
    logic [IRW-1:0] vji_ir_out;
    logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    nios2_debug_vjtag_master #(
        .TCK_DIV(DIV0), .DR_WIDTH(DRW), .IR_WIDTH(IRW), .RTI_PERIODS(RTI)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ir_out(rsp_ir_out),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
        .vji_rti(vji_rti)
    );

    // Slave model: loads a value on CDR, shifts LSB-first on SDR, latches what it saw on UDR.
    logic [DRW-1:0] slv_load = '0;
    logic [IRW-1:0] slv_irout = '0;
    logic [DRW-1:0] slv_sr;
    logic [DRW-1:0] slv_seen;
    logic [IRW-1:0] slv_ir_seen;
    assign vji_tdo    = slv_sr[0];
    assign vji_ir_out = slv_irout;

    always @(posedge vji_tck or negedge reset_n) begin
        if (!reset_n) begin
            slv_sr      <= '0;
            slv_seen    <= '0;
            slv_ir_seen <= '0;
        end else begin
            if (vji_cdr) slv_sr <= slv_load;
            else if (vji_sdr) slv_sr <= {vji_tdi, slv_sr[DRW-1:1]};
            if (vji_udr) slv_seen <= slv_sr;
            if (vji_uir) slv_ir_seen <= vji_ir_in;
        end
    end

    // ---------------- DUT 1: TCK_DIV=1, all-ones loopback ----------------
    logic           cmd1_valid = 1'b0;
    logic           cmd1_ready;
    logic [IRW-1:0] cmd1_ir = '0;
    logic [DRW-1:0] cmd1_data = '0;
    logic           rsp1_valid;
    logic           rsp1_ready = 1'b1;
    logic [DRW-1:0] rsp1_data;
    logic [IRW-1:0] rsp1_ir_out;
    logic           vji1_tck, vji1_tdi;
    logic           vji1_tdo = 1'b1;
    logic [IRW-1:0] vji1_ir_in;
    logic [IRW-1:0] vji1_ir_out = '0;
    logic           vji1_uir, vji1_cdr, vji1_sdr, vji1_udr, vji1_rti;

    nios2_debug_vjtag_master #(
        .TCK_DIV(DIV1), .DR_WIDTH(DRW), .IR_WIDTH(IRW), .RTI_PERIODS(RTI)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd1_valid), .cmd_ready(cmd1_ready), .cmd_ir(cmd1_ir),
        .cmd_data(cmd1_data),
        .rsp_valid(rsp1_valid), .rsp_ready(rsp1_ready), .rsp_data(rsp1_data),
        .rsp_ir_out(rsp1_ir_out),
        .vji_tck(vji1_tck), .vji_tdi(vji1_tdi), .vji_tdo(vji1_tdo),
        .vji_ir_in(vji1_ir_in), .vji_ir_out(vji1_ir_out),
        .vji_uir(vji1_uir), .vji_cdr(vji1_cdr), .vji_sdr(vji1_sdr), .vji_udr(vji1_udr),
        .vji_rti(vji1_rti)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DRW-1:0] data;
        logic [IRW-1:0] ir;
        logic [DRW-1:0] load;
        logic [IRW-1:0] irout;
        int             acc;
    } exp_t;

    exp_t sb[$];
    int   n_sent = 0;
    int   n_done = 0;
    int   last_hs_cyc = 0;
    int   bp_tab[16];

    // Consumer: per-response backpressure taken from bp_tab.
    int n_rsp = 0;
    int bp_cnt = 0;
    bit in_rsp = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    bp_cnt = bp_tab[n_rsp % 16];
                    n_rsp++;
                end else if (bp_cnt > 0) begin
                    bp_cnt--;
                end
                rsp_ready = (bp_cnt == 0);
            end else begin
                in_rsp    = 1'b0;
                rsp_ready = 1'b1;
            end
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each new response.
    logic [5:0]     prev_outs = '0;
    logic [IRW-1:0] prev_ir_in = '0;
    logic [DRW-1:0] held = '0;
    bit prev_rv = 0, prev_hs = 0, prev_tck = 0, prev_acc = 0, prev_sdr = 0;
    int run_uir = 0, run_cdr = 0, run_udr = 0, run_rti = 0, sdr_rises = 0;

    always @(negedge clk) begin
        logic [5:0] outs;
        exp_t e;
        outs = {vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
        if (!reset_n) begin
            prev_rv = 0; prev_hs = 0; prev_tck = 0; prev_acc = 0; prev_sdr = 0;
            run_uir = 0; run_cdr = 0; run_udr = 0; run_rti = 0; sdr_rises = 0;
            prev_outs = outs;
            prev_ir_in = vji_ir_in;
        end else begin
            if (vji_tck) chk("vji_stable_while_tck_high", outs, prev_outs);
            if (vji_ir_in !== prev_ir_in) chk("ir_in_changes_only_at_accept", prev_acc, 1);

            if (vji_uir) run_uir++;
            else if (run_uir != 0) begin chk("uir_clk_len", run_uir, 2 * DIV0); run_uir = 0; end
            if (vji_cdr) run_cdr++;
            else if (run_cdr != 0) begin chk("cdr_clk_len", run_cdr, 2 * DIV0); run_cdr = 0; end
            if (vji_udr) run_udr++;
            else if (run_udr != 0) begin chk("udr_clk_len", run_udr, 2 * DIV0); run_udr = 0; end
            if (vji_rti) run_rti++;
            else if (run_rti != 0) begin
                chk("rti_clk_len", run_rti, 2 * DIV0 * RTI);
                run_rti = 0;
            end
            if (vji_sdr) begin
                if (vji_tck && !prev_tck) sdr_rises++;
            end else if (prev_sdr) begin
                chk("sdr_tck_rises", sdr_rises, DRW);
                sdr_rises = 0;
            end

            if (rsp_valid && !prev_rv) begin
                if (sb.size() == 0) begin
                    chk("unexpected_response", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_data", rsp_data, e.load);
                    chk("rsp_ir_out", rsp_ir_out, e.irout);
                    chk("rsp_latency", cyc - e.acc, LAT0);
                    chk("slave_saw_dr", slv_seen, e.data);
                    chk("slave_saw_ir", slv_ir_seen, e.ir);
                    chk("vji_ir_in_held", vji_ir_in, e.ir);
                    n_done++;
                end
                held = rsp_data;
            end else if (rsp_valid) begin
                chk("rsp_data_held", rsp_data, held);
                chk("cmd_ready_low_in_resp", cmd_ready, 0);
                chk("tck_low_in_resp", vji_tck, 0);
            end
            if (prev_hs) chk("cmd_ready_after_handshake", cmd_ready, 1);

            prev_hs = rsp_valid && rsp_ready;
            if (prev_hs) last_hs_cyc = cyc;
            prev_acc   = cmd_valid && cmd_ready;
            prev_rv    = rsp_valid;
            prev_tck   = vji_tck;
            prev_sdr   = vji_sdr;
            prev_outs  = outs;
            prev_ir_in = vji_ir_in;
        end
    end

    // Driver: present a command, wait for accept, then arm the slave for it.
    task automatic send(input logic [DRW-1:0] d, input logic [IRW-1:0] ir,
                        input logic [DRW-1:0] load, input logic [IRW-1:0] irout,
                        input bit hold, input bit track, input bit b2b);
        int n;
        exp_t e;
        n = 0;
        cmd_data  = d;
        cmd_ir    = ir;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        if (b2b) chk("b2b_accept_gap", cyc - last_hs_cyc, 1);
        if (track) begin
            e.data = d; e.ir = ir; e.load = load; e.irout = irout; e.acc = cyc;
            sb.push_back(e);
            n_sent++;
        end
        @(posedge clk);
        #1;
        slv_load  = load;
        slv_irout = irout;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic run_div1();
        logic [DRW-1:0] d;
        logic [IRW-1:0] ir;
        logic [IRW-1:0] iro;
        int a;
        int n;
        for (int k = 0; k < 3; k++) begin
            d   = rnd38();
            ir  = IRW'($urandom);
            iro = IRW'($urandom);
            vji1_ir_out = iro;
            cmd1_data   = d;
            cmd1_ir     = ir;
            cmd1_valid  = 1'b1;
            n = 0;
            @(negedge clk);
            while (!cmd1_ready && n < 500) begin
                n++;
                @(negedge clk);
            end
            a = cyc;
            @(posedge clk);
            #1;
            cmd1_valid = 1'b0;
            n = 0;
            @(negedge clk);
            while (!rsp1_valid && n < 500) begin
                n++;
                @(negedge clk);
            end
            chk("div1_latency", cyc - a, LAT1);
            chk("div1_rsp_data_ones", rsp1_data, {DRW{1'b1}});
            chk("div1_rsp_ir_out", rsp1_ir_out, iro);
            chk("div1_vji_ir_in", vji1_ir_in, ir);
        end
    endtask

    initial begin
        logic [IRW-1:0] ir;
        bit prev_h;
        bit h;
        bit rv_seen;
        int n;

        bp_tab[0] = 0;
        bp_tab[1] = 50;
        bp_tab[2] = 0;
        bp_tab[3] = 0;
        for (int i = 4; i < 16; i++) bp_tab[i] = $urandom_range(0, 5);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero",
            {rsp_data, rsp_ir_out, vji_ir_in, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr,
             vji_udr, vji_rti, rsp_valid}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("cmd_ready_after_reset", cmd_ready, 1);

        fork
            begin
                send(38'h2A_AAAA_AAAA, 2'b10, 38'h15_5555_5555, 2'b01, 0, 1, 0);
                send(rnd38(), 2'b01, rnd38(), 2'b11, 0, 1, 0);
                ir = 2'b11;
                send(rnd38(), ir, rnd38(), 2'b10, 1, 1, 0);
                send(rnd38(), ~ir, rnd38(), 2'b01, 0, 1, 1);
                prev_h = 0;
                for (int i = 0; i < 6; i++) begin
                    h = (i == 5) ? 1'b0 : 1'($urandom);
                    send(rnd38(), IRW'($urandom), rnd38(), IRW'($urandom), h, 1, prev_h);
                    prev_h = h;
                end
            end
            run_div1();
        join

        n = 0;
        while (n_done < n_sent && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("scoreboard_drained", n_done, n_sent);

        // Abort a scan mid-SDR with an asynchronous reset.
        send(rnd38(), 2'b11, rnd38(), 2'b10, 0, 0, 0);
        n = 0;
        while (!vji_sdr && n < 500) begin
            n++;
            @(negedge clk);
        end
        repeat (20) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_sdr_vji_zero",
            {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_ir_in}, 0);
        chk("reset_mid_sdr_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("cmd_ready_after_abort", cmd_ready, 1);
        rv_seen = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (rsp_valid) rv_seen = 1'b1;
        end
        chk("no_response_after_abort", rv_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
